fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares one synchronous FIFO write port between NUM_REQ independent producers.
- Sits directly in front of the FIFO write side:
  - drives the FIFO's wr_en and w_data;
  - observes the FIFO's full flag;
  - returns a per-producer grant so each producer knows exactly when its word was accepted.
- Arbitration state is registered (rotating pointer, optional burst lock); the grant path is combinational, so an accepted word enters the FIFO on the same clock edge.

---
 rtl/fifo_wr_arbiter.sv | 156 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing one synchronous FIFO write port between
//   NUM_REQ producers. Arbitration state (rotating pointer, burst lock) is
//   registered; the grant path is combinational, so a granted word enters
//   the FIFO on the same rising edge that gnt is high.
//
//   Optional feature macro: FIFO_ARB_BURST_EN
//     defined   -> a producer that wins from IDLE keeps the port for up to
//                  MAX_BURST consecutive grants while it keeps requesting.
//     undefined -> plain round-robin; the grant rotates after every word.
//
// Ports
//   clk        : rising-edge clock shared with the FIFO
//   rst        : synchronous active-high reset
//   req        : per-producer write request, held with stable data until gnt
//   req_data   : producer words, producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt        : one-hot accept, word is written at this rising edge
//   wr_en      : FIFO write enable (|gnt)
//   w_data     : granted producer's word, zero when no grant
//   full       : FIFO full flag, blocks all grants combinationally
//   last_id    : registered index of the most recently granted producer
//   last_valid : registered, high for one cycle after each grant
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         w_data,
  input  logic                          full,
  output logic [$clog2(NUM_REQ)-1:0]    last_id,
  output logic                          last_valid
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int SW    = IDW + 1;
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [SW-1:0]  NUM_REQ_W = SW'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t             state_reg, state_next;
  logic [IDW-1:0]     ptr_reg, ptr_next;
  logic [IDW-1:0]     lock_id_reg, lock_id_next;
  logic [CNT_W-1:0]   burst_cnt_reg, burst_cnt_next;
  logic [IDW-1:0]     last_id_reg, last_id_next;
  logic               last_valid_reg, last_valid_next;

  logic               rr_found;
  logic [IDW-1:0]     rr_win;
  logic [SW-1:0]      rr_idx;
  logic               use_lock;
  logic [IDW-1:0]     win;
  logic               grant_ok;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  // Rotating priority search: first requester at ptr, ptr+1, ... (mod NUM_REQ).
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    rr_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = {1'b0, ptr_reg} + SW'(k);
      if (rr_idx >= NUM_REQ_W) rr_idx = rr_idx - NUM_REQ_W;
      if (!rr_found && req[rr_idx[IDW-1:0]]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx[IDW-1:0];
      end
    end
  end

  // A lock holder that dropped its request falls back to the rotating search
  // in the same cycle, so the port never idles while anyone else is waiting.
  assign use_lock = (state_reg == LOCKED) && req[lock_id_reg];
  assign win      = use_lock ? lock_id_reg : rr_win;
  assign grant_ok = (use_lock || rr_found) && !full && !rst;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
      assign gnt[gi]      = grant_ok && (win == IDW'(gi));
      assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign wr_en      = grant_ok;
  assign w_data     = grant_ok ? data_arr[win] : '0;
  assign last_id    = last_id_reg;
  assign last_valid = last_valid_reg;

  // Next-state logic. full (and rst, via grant_ok) freezes everything except
  // last_valid, which simply reports that no word was written.
  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    lock_id_next    = lock_id_reg;
    burst_cnt_next  = burst_cnt_reg;
    last_id_next    = last_id_reg;
    last_valid_next = 1'b0;

    if (grant_ok) begin
      ptr_next        = (win == LAST_ID) ? '0 : win + 1'b1;
      last_id_next    = win;
      last_valid_next = 1'b1;
`ifdef FIFO_ARB_BURST_EN
      if (use_lock) begin
        if (burst_cnt_reg == CNT_W'(MAX_BURST - 1)) begin
          state_next     = IDLE;
          burst_cnt_next = '0;
        end else begin
          burst_cnt_next = burst_cnt_reg + 1'b1;
        end
      end else if (MAX_BURST > 1) begin
        // Fresh win (from IDLE or from a released lock) opens a new burst.
        state_next     = LOCKED;
        lock_id_next   = win;
        burst_cnt_next = CNT_W'(1);
      end else begin
        state_next     = IDLE;
        burst_cnt_next = '0;
      end
`endif
    end
`ifdef FIFO_ARB_BURST_EN
    else if (!full && (state_reg == LOCKED) && !req[lock_id_reg]) begin
      // Holder left and nobody else asked: release the lock anyway.
      state_next     = IDLE;
      burst_cnt_next = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      ptr_reg        <= '0;
      lock_id_reg    <= '0;
      burst_cnt_reg  <= '0;
      last_id_reg    <= '0;
      last_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      lock_id_reg    <= lock_id_next;
      burst_cnt_reg  <= burst_cnt_next;
      last_id_reg    <= last_id_next;
      last_valid_reg <= last_valid_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a depth-8 FIFO model on the
// write side. Burst-mode vectors are selected by FIFO_ARB_BURST_EN.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        wr_en;
  logic [7:0]  w_data;
  logic        full;
  logic [1:0]  last_id;
  logic        last_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .wr_en      (wr_en),
    .w_data     (w_data),
    .full       (full),
    .last_id    (last_id),
    .last_valid (last_valid)
  );

  // Depth-8 FIFO model fed by the arbiter.
  logic [7:0] fmem [8];
  int         fcnt = 0;
  int         frp  = 0;
  int         fwp  = 0;
  logic       rd   = 1'b0;

  assign full = (fcnt == 8);

  always @(posedge clk) begin
    if (wr_en && fcnt < 8) begin
      fmem[fwp] <= w_data;
      fwp       <= (fwp + 1) % 8;
    end
    if (rd && fcnt > 0) frp <= (frp + 1) % 8;
    fcnt <= fcnt + ((wr_en && fcnt < 8) ? 1 : 0) - ((rd && fcnt > 0) ? 1 : 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect a grant (or none) in the current cycle, then advance one clock.
  task automatic grant_cycle(input string tag, input logic [3:0] exp_gnt);
    logic [7:0] exp_data;
    exp_data = 8'h00;
    for (int i = 0; i < 4; i++) if (exp_gnt[i]) exp_data = 8'(8'h10 * (i + 1));
    #2;
    check({tag, "_gnt"}, {28'd0, gnt}, {28'd0, exp_gnt});
    check({tag, "_data"}, {24'd0, w_data}, {24'd0, exp_data});
    tick();
  endtask

  task automatic drain();
    req = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      rd = 1'b1;
      tick();
    end
    rd = 1'b0;
  endtask

  int gcnt;

  initial begin
    rst      = 1'b1;
    req      = 4'b1111;
    req_data = {8'h40, 8'h30, 8'h20, 8'h10};
    #1;

    // Reset held with every producer requesting.
    for (int i = 0; i < 3; i++) begin
      #2;
      check("rst_gnt", {28'd0, gnt}, 32'd0);
      check("rst_wr_en", {31'd0, wr_en}, 32'd0);
      check("rst_w_data", {24'd0, w_data}, 32'd0);
      tick();
      check("rst_last_valid", {31'd0, last_valid}, 32'd0);
    end
    rst = 1'b0;

`ifdef FIFO_ARB_BURST_EN
    rd = 1'b1;
    grant_cycle("first", 4'b0001);
    // Lock 0 already used one of its four grants.
    grant_cycle("b0", 4'b0001);
    grant_cycle("b0", 4'b0001);
    grant_cycle("b0", 4'b0001);
    req = 4'b0011;
    grant_cycle("b1", 4'b0010);
    grant_cycle("b1", 4'b0010);
    grant_cycle("b1", 4'b0010);
    grant_cycle("b1", 4'b0010);
    grant_cycle("b_back0", 4'b0001);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0011;
    grant_cycle("drop_0", 4'b0001);
    grant_cycle("drop_0", 4'b0001);
    req = 4'b0010;
    grant_cycle("drop_to1", 4'b0010);
    req = 4'b0011;
    grant_cycle("held_1", 4'b0010);

    rst = 1'b1;
    #1;
    check("midrst_gnt", {28'd0, gnt}, 32'd0);
    tick();
    rst = 1'b0;
    grant_cycle("post_rst", 4'b0001);
    grant_cycle("post_rst", 4'b0001);
    grant_cycle("post_rst", 4'b0001);
    grant_cycle("post_rst", 4'b0001);
    grant_cycle("post_rst_next", 4'b0010);
    rd = 1'b0;
`else
    // Round robin with all four producers requesting.
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        check("rr_last_id", {30'd0, last_id}, 32'((i - 1) % 4));
        check("rr_last_valid", {31'd0, last_valid}, 32'd1);
      end
      grant_cycle("rr", 4'(1 << (i % 4)));
    end
    check("rr_last_id_end", {30'd0, last_id}, 32'd3);
    req = 4'b0000;
    grant_cycle("idle", 4'b0000);
    check("idle_last_valid", {31'd0, last_valid}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      #2;
      check("fifo_rd", {24'd0, fmem[frp]}, 32'(8'h10 * ((i % 4) + 1)));
      rd = 1'b1;
      tick();
      rd = 1'b0;
    end

    // Full stall: 12 cycles of requests into an empty depth-8 FIFO.
    req  = 4'b0011;
    gcnt = 0;
    for (int i = 0; i < 12; i++) begin
      #2;
      if (gnt != 4'b0000) gcnt++;
      if (i < 8) check("fill_gnt", {28'd0, gnt}, (i % 2 == 1) ? 32'd2 : 32'd1);
      else       check("stall_gnt", {28'd0, gnt}, 32'd0);
      tick();
    end
    check("stall_count", gcnt, 32'd8);
    check("stall_last_id", {30'd0, last_id}, 32'd1);
    rd = 1'b1;
    grant_cycle("read_cycle", 4'b0000);
    rd = 1'b0;
    grant_cycle("after_read", 4'b0001);
    grant_cycle("refull", 4'b0000);
    drain();

    // ptr is 1 here; granting producer 2 moves it to 3.
    req = 4'b0100;
    grant_cycle("to_ptr3", 4'b0100);
    req = 4'b0101;
    grant_cycle("wrap0", 4'b0001);
    check("wrap_last_id", {30'd0, last_id}, 32'd0);
    grant_cycle("wrap2", 4'b0100);
    check("wrap_last_id", {30'd0, last_id}, 32'd2);
    grant_cycle("wrap0b", 4'b0001);
    drain();

    // Reset in the middle of operation with ptr away from 0.
    req = 4'b1111;
    #2;
    check("pre_rst_gnt", {28'd0, gnt}, 32'd2);
    rst = 1'b1;
    #1;
    check("midrst_gnt", {28'd0, gnt}, 32'd0);
    tick();
    rst = 1'b0;
    grant_cycle("post_rst", 4'b0001);
    req = 4'b0000;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
